irq_ctrl: RTL

- Upstream stage for the 8-to-3 priority encoder. Collects eight raw interrupt lines and synchronises them.
- Holds per-line pending state (edge or level mode) and applies a mask. Drives the masked pending vector into an `encoder` instance.
- Wraps the encoder's combinational index/valid in a request/acknowledge/end-of-interrupt handshake to a single service agent.
- The encoder gives fixed priority: line 7 highest, line 0 lowest.

---
 rtl/irq_pkg.sv | 13 +
 rtl/encoder.sv | 20 ++
 rtl/irq_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and sizes for the interrupt controller slice.
package irq_pkg;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

endpackage

// File: rtl/encoder.sv
// 8-to-3 fixed-priority encoder: line 7 highest, line 0 lowest.
module encoder (
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    out   = '0;
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in[i]) begin
        out   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt collector: synchronises raw lines, keeps edge/level pending state,
// masks, arbitrates through the encoder and runs the req/ack/eoi handshake.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] edge_mode,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  logic [NUM_IRQ-1:0] sync;
  logic [NUM_IRQ-1:0] sync_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] masked;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [ID_W-1:0]    enc_out;
  logic               enc_valid;
  state_t             state, next_state;
  logic [ID_W-1:0]    next_id;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync = irq_in;
    end else begin : g_sync
      for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        logic [SYNC_STAGES-1:0] chain;
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
          if (rst) begin
            chain <= '0;
          end else begin
            chain[0] <= irq_in[i];
            for (int s = 1; s < SYNC_STAGES; s++) chain[s] <= chain[s-1];
          end
        end
        assign sync[i] = chain[SYNC_STAGES-1];
      end
    end
  endgenerate

  // sync_d resets low, so a line already high at reset release yields one rise.
  always_ff @(posedge clk) begin
    if (rst) sync_d <= '0;
    else     sync_d <= sync;
  end

  assign rise   = sync & ~sync_d;
  assign masked = pending & ~mask;

  always_comb begin
    ack_clr = '0;
    if (state == REQ && irq_ack) ack_clr[irq_id] = 1'b1;
  end

  // Edge mode: a new rise beats a same-cycle ack clear so the edge is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (!edge_mode[i])   pending[i] <= sync[i];
        else if (rise[i])    pending[i] <= 1'b1;
        else if (ack_clr[i]) pending[i] <= 1'b0;
      end
    end
  end

  encoder u_encoder (
    .in    (masked),
    .out   (enc_out),
    .valid (enc_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state  <= next_state;
      irq_id <= next_id;
    end
  end

  // irq_id is latched only on IDLE->REQ, so later arrivals never pre-empt.
  always_comb begin
    next_state = state;
    next_id    = irq_id;
    unique case (state)
      IDLE: begin
        if (enc_valid) begin
          next_state = REQ;
          next_id    = enc_out;
        end
      end
      REQ: begin
        if (irq_ack)              next_state = SERVICE;
        else if (!masked[irq_id]) next_state = IDLE;
      end
      SERVICE: begin
        if (irq_eoi) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign irq_req    = (state == REQ);
  assign in_service = (state == SERVICE);

endmodule
